// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings and defaults for the fetch/data memory
//               port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_MEM_LATENCY = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arb_gnt_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Pipeline-side and memory-side signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ready;
    logic                  dm_read;
    logic                  dm_write;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_ready;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  stall_if;
    logic                  stall_mem;

    modport slave (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one fixed-latency single-port memory between fetch and
//               data access; data has priority with one-shot fetch fairness.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
)(
    input  wire logic           clk,
    input  wire logic           rst,
    mem_port_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    arb_state_t            state_q,    state_d;
    arb_gnt_t              gnt_q,      gnt_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  fair_q,     fair_d;
    logic                  we_q,       we_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  if_ready_q, if_ready_d;
    logic                  dm_ready_q, dm_ready_d;
    logic                  w_dm_req;

    assign w_dm_req = bus.dm_read | bus.dm_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= GNT_IF;
            cnt_q      <= '0;
            fair_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            fair_q     <= fair_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        fair_d     = fair_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (bus.if_req || w_dm_req) begin
                    state_d = ARB_ISSUE;
                    // A pending fairness token lets a waiting fetch jump ahead once.
                    if (w_dm_req && !(fair_q && bus.if_req)) begin
                        gnt_d   = GNT_DM;
                        we_d    = bus.dm_write;
                        addr_d  = bus.dm_addr;
                        wdata_d = bus.dm_wdata;
                    end else begin
                        gnt_d   = GNT_IF;
                        we_d    = 1'b0;
                        addr_d  = bus.if_addr;
                        fair_d  = 1'b0;
                    end
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
                cnt_d   = CNT_W'(MEM_LATENCY);
            end
            ARB_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ARB_DONE;
                    if (!we_q) begin
                        if (gnt_q == GNT_IF) if_rdata_d = bus.mem_rdata;
                        else                 dm_rdata_d = bus.mem_rdata;
                    end
                    if_ready_d = (gnt_q == GNT_IF);
                    dm_ready_d = (gnt_q == GNT_DM);
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
                if (gnt_q == GNT_DM && bus.if_req) fair_d = 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.mem_en    = (state_q == ARB_ISSUE);
    assign bus.mem_we    = we_q & (state_q == ARB_ISSUE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.stall_if  = bus.if_req & ~if_ready_q;
    assign bus.stall_mem = w_dm_req & ~dm_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a fixed-latency
//               ROM model and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SLOT = LAT + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents; word 16 (address 0x40) holds the fetch-test instruction.
    function automatic logic [31:0] rom(input logic [31:0] addr);
        logic [7:0] idx;
        idx = addr[9:2];
        if (idx == 8'd16) return 32'h8C22_0004;
        return {8'hA5, idx, ~idx, 8'h3C};
    endfunction

    // Memory model: data for an mem_en in cycle C is presented only in cycle C+LAT.
    logic        pipe_v [1:LAT];
    logic [31:0] pipe_d [1:LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= LAT; k++) pipe_v[k] <= 1'b0;
        end else begin
            pipe_v[1] <= bus.mem_en;
            pipe_d[1] <= rom(bus.mem_addr);
            for (int k = 2; k <= LAT; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_d[k] <= pipe_d[k-1];
            end
        end
    end
    assign bus.mem_rdata = pipe_v[LAT] ? pipe_d[LAT] : (32'hBAD0_0000 | 32'(cyc[15:0]));

    // Observation records for one scenario window.
    int          en_cyc[$];
    logic        en_we[$];
    logic [31:0] en_addr[$];
    logic [31:0] en_wd[$];
    int          ifr_cyc[$];
    logic [31:0] ifr_dat[$];
    int          dmr_cyc[$];
    logic [31:0] dmr_dat[$];
    logic [63:0] st_if, st_mem;

    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_dm_rdata = 32'h0;
    bit          fair_m = 1'b0;

    // Samples n cycles; each requester drops after its given number of ready pulses.
    task automatic observe(input int n, input int if_hold, input int dm_hold);
        int nif = 0;
        int ndm = 0;
        en_cyc.delete(); en_we.delete(); en_addr.delete(); en_wd.delete();
        ifr_cyc.delete(); ifr_dat.delete(); dmr_cyc.delete(); dmr_dat.delete();
        st_if = '0; st_mem = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            st_if[c]  = bus.stall_if;
            st_mem[c] = bus.stall_mem;
            if (bus.mem_en) begin
                en_cyc.push_back(c); en_we.push_back(bus.mem_we);
                en_addr.push_back(bus.mem_addr); en_wd.push_back(bus.mem_wdata);
            end
            if (bus.if_ready) begin
                ifr_cyc.push_back(c); ifr_dat.push_back(bus.if_rdata);
                nif++;
                if (nif >= if_hold) bus.if_req = 1'b0;
            end
            if (bus.dm_ready) begin
                dmr_cyc.push_back(c); dmr_dat.push_back(bus.dm_rdata);
                ndm++;
                if (ndm >= dm_hold) begin bus.dm_read = 1'b0; bus.dm_write = 1'b0; end
            end
        end
    endtask

    task automatic start_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.if_req = 1'b1; bus.if_addr = '0; bus.dm_read = 1'b0; bus.dm_write = 1'b0;
        bus.dm_addr = '0; bus.dm_wdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.if_rdata, bus.dm_rdata, bus.mem_addr, bus.mem_wdata} !== 128'h0 ||
            {bus.if_ready, bus.dm_ready, bus.mem_en, bus.mem_we, bus.stall_mem} !== 5'b0)
            $display("FAIL reset_outputs: got if_rdata=%h dm_rdata=%h mem_addr=%h en=%b we=%b, want all 0",
                     bus.if_rdata, bus.dm_rdata, bus.mem_addr, bus.mem_en, bus.mem_we);
        else n_pass++;
        n_checks++;
        if (bus.stall_if !== 1'b1) $display("FAIL reset_stall_if_req: got %b want 1", bus.stall_if);
        else n_pass++;
        bus.if_req = 1'b0;
        #1;
        n_checks++;
        if (bus.stall_if !== 1'b0) $display("FAIL reset_stall_if_idle: got %b want 0", bus.stall_if);
        else n_pass++;
        start_cycle();
        rst = 1'b0;
    endtask

    task automatic test_fetch_only();
        start_cycle();
        bus.if_addr = 32'h40; bus.if_req = 1'b1;
        observe(8, 1, 1);
        exp_if_rdata = 32'h8C22_0004;
        n_checks++;
        if (en_cyc.size() != 1 || en_cyc[0] != 1 || en_we[0] !== 1'b0 || en_addr[0] !== 32'h40)
            $display("FAIL fetch_mem_en: got n=%0d cyc=%0d we=%b addr=%h want n=1 cyc=1 we=0 addr=00000040",
                     en_cyc.size(), en_cyc[0], en_we[0], en_addr[0]);
        else n_pass++;
        n_checks++;
        if (ifr_cyc.size() != 1 || ifr_cyc[0] != 4 || ifr_dat[0] !== exp_if_rdata)
            $display("FAIL fetch_ready: got n=%0d cyc=%0d data=%h want n=1 cyc=4 data=%h",
                     ifr_cyc.size(), ifr_cyc[0], ifr_dat[0], exp_if_rdata);
        else n_pass++;
        n_checks++;
        if (st_if[7:0] !== 8'b0000_1111) $display("FAIL fetch_stall_if: got %b want 00001111", st_if[7:0]);
        else n_pass++;
        n_checks++;
        if (bus.if_rdata !== exp_if_rdata || dmr_cyc.size() != 0)
            $display("FAIL fetch_hold: got if_rdata=%h dm_ready_n=%0d want %h and 0", bus.if_rdata, dmr_cyc.size(), exp_if_rdata);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        start_cycle();
        bus.if_addr = 32'h44; bus.if_req = 1'b1;
        bus.dm_addr = 32'h100; bus.dm_read = 1'b1;
        observe(12, 1, 1);
        exp_dm_rdata = rom(32'h100);
        exp_if_rdata = rom(32'h44);
        n_checks++;
        if (en_cyc.size() != 2 || en_cyc[0] != 1 || en_cyc[1] != 6 ||
            en_addr[0] !== 32'h100 || en_addr[1] !== 32'h44)
            $display("FAIL simul_order: got n=%0d cyc=%0d,%0d addr=%h,%h want 2 cyc=1,6 addr=00000100,00000044",
                     en_cyc.size(), en_cyc[0], en_cyc[1], en_addr[0], en_addr[1]);
        else n_pass++;
        n_checks++;
        if (dmr_cyc.size() != 1 || dmr_cyc[0] != 4 || dmr_dat[0] !== exp_dm_rdata)
            $display("FAIL simul_dm_ready: got cyc=%0d data=%h want cyc=4 data=%h", dmr_cyc[0], dmr_dat[0], exp_dm_rdata);
        else n_pass++;
        n_checks++;
        if (ifr_cyc.size() != 1 || ifr_cyc[0] != 9 || ifr_dat[0] !== exp_if_rdata)
            $display("FAIL simul_if_ready: got cyc=%0d data=%h want cyc=9 data=%h", ifr_cyc[0], ifr_dat[0], exp_if_rdata);
        else n_pass++;
    endtask

    task automatic test_fairness();
        start_cycle();
        bus.if_addr = 32'h48; bus.if_req = 1'b1;
        bus.dm_addr = 32'h104; bus.dm_read = 1'b1;
        observe(18, 1, 2);
        exp_dm_rdata = rom(32'h104);
        exp_if_rdata = rom(32'h48);
        n_checks++;
        if (en_cyc.size() != 3 || en_addr[0] !== 32'h104 || en_addr[1] !== 32'h48 || en_addr[2] !== 32'h104)
            $display("FAIL fair_order: got n=%0d addr=%h,%h,%h want 3 addr=00000104,00000048,00000104",
                     en_cyc.size(), en_addr[0], en_addr[1], en_addr[2]);
        else n_pass++;
        n_checks++;
        if (ifr_cyc.size() != 1 || ifr_cyc[0] != 9 || dmr_cyc.size() != 2 || dmr_cyc[0] != 4 || dmr_cyc[1] != 14)
            $display("FAIL fair_timing: got if_cyc=%0d dm_cyc=%0d,%0d want if=9 dm=4,14", ifr_cyc[0], dmr_cyc[0], dmr_cyc[1]);
        else n_pass++;
    endtask

    task automatic test_store();
        for (int rd = 0; rd < 2; rd++) begin
            start_cycle();
            bus.dm_addr = 32'h200; bus.dm_wdata = 32'hDEAD_BEEF;
            bus.dm_write = 1'b1; bus.dm_read = rd[0];
            observe(7, 1, 1);
            n_checks++;
            if (en_cyc.size() != 1 || en_cyc[0] != 1 || en_we[0] !== 1'b1 ||
                en_addr[0] !== 32'h200 || en_wd[0] !== 32'hDEAD_BEEF)
                $display("FAIL store_cmd rd=%0d: got n=%0d cyc=%0d we=%b addr=%h wd=%h want 1 cyc=1 we=1 addr=00000200 wd=deadbeef",
                         rd, en_cyc.size(), en_cyc[0], en_we[0], en_addr[0], en_wd[0]);
            else n_pass++;
            n_checks++;
            if (dmr_cyc.size() != 1 || dmr_cyc[0] != 4 || bus.dm_rdata !== exp_dm_rdata)
                $display("FAIL store_ready rd=%0d: got cyc=%0d dm_rdata=%h want cyc=4 dm_rdata=%h",
                         rd, dmr_cyc[0], bus.dm_rdata, exp_dm_rdata);
            else n_pass++;
        end
    endtask

    task automatic test_reset_wait();
        start_cycle();
        bus.if_addr = 32'h40; bus.if_req = 1'b1;
        start_cycle();
        start_cycle();
        rst = 1'b1; bus.if_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.if_rdata, bus.dm_rdata, bus.mem_addr, bus.mem_wdata} !== 128'h0 ||
            {bus.if_ready, bus.dm_ready, bus.mem_en, bus.mem_we} !== 4'b0)
            $display("FAIL rstwait_outputs: got if_rdata=%h dm_rdata=%h mem_addr=%h mem_wdata=%h want all 0",
                     bus.if_rdata, bus.dm_rdata, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
        start_cycle();
        rst = 1'b0;
        exp_if_rdata = '0; exp_dm_rdata = '0;
        observe(8, 1, 1);
        n_checks++;
        if (en_cyc.size() != 0 || ifr_cyc.size() != 0 || dmr_cyc.size() != 0)
            $display("FAIL rstwait_quiet: got en=%0d if_ready=%0d dm_ready=%0d want 0 0 0",
                     en_cyc.size(), ifr_cyc.size(), dmr_cyc.size());
        else n_pass++;
        start_cycle();
        bus.dm_addr = 32'h10C; bus.dm_read = 1'b1;
        observe(7, 1, 1);
        exp_dm_rdata = rom(32'h10C);
        n_checks++;
        if (en_cyc.size() != 1 || en_cyc[0] != 1 || dmr_cyc.size() != 1 || dmr_cyc[0] != 4 || dmr_dat[0] !== exp_dm_rdata)
            $display("FAIL rstwait_fresh: got en_cyc=%0d rdy_cyc=%0d data=%h want 1 4 %h",
                     en_cyc[0], dmr_cyc[0], dmr_dat[0], exp_dm_rdata);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            bit          want_if, dr, dw, dm, if_done;
            logic [31:0] ia, da, wd;
            int          order[2];
            int          n, t_if, t_dm;
            logic [13:0] x_if, x_mem;
            int          r;
            r = $urandom_range(1, 7);
            want_if = r[0]; dr = r[1]; dw = r[2]; dm = dr | dw;
            ia = 32'($urandom_range(0, 15)) << 2;
            da = 32'($urandom_range(0, 15)) << 2;
            wd = $urandom;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            start_cycle();
            bus.if_addr = ia; bus.if_req = want_if;
            bus.dm_addr = da; bus.dm_wdata = wd; bus.dm_read = dr; bus.dm_write = dw;

            // Reference: data first unless the fairness token favours a waiting fetch.
            n = 0;
            if (dm && !(fair_m && want_if)) begin order[n] = 1; n++; end
            if (want_if) begin order[n] = 0; n++; end
            if (dm && (fair_m && want_if)) begin order[n] = 1; n++; end
            t_if = 99; t_dm = 99; if_done = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (order[k] == 0) begin t_if = SLOT*k + LAT + 2; fair_m = 1'b0; if_done = 1'b1; end
                else begin
                    t_dm = SLOT*k + LAT + 2;
                    if (want_if && !if_done) fair_m = 1'b1;
                end
            end
            for (int c = 0; c < 14; c++) begin
                x_if[c]  = want_if && (c < t_if);
                x_mem[c] = dm && (c < t_dm);
            end

            observe(14, 1, 1);

            n_checks++;
            if (en_cyc.size() != n) $display("FAIL rand%0d_count: got %0d want %0d", it, en_cyc.size(), n);
            else n_pass++;
            for (int k = 0; k < n; k++) begin
                n_checks++;
                if (order[k] == 1) begin
                    if (en_cyc[k] != SLOT*k + 1 || en_we[k] !== dw || en_addr[k] !== da || (dw && en_wd[k] !== wd))
                        $display("FAIL rand%0d_dm_cmd: got cyc=%0d we=%b addr=%h wd=%h want cyc=%0d we=%b addr=%h wd=%h",
                                 it, en_cyc[k], en_we[k], en_addr[k], en_wd[k], SLOT*k + 1, dw, da, wd);
                    else n_pass++;
                end else begin
                    if (en_cyc[k] != SLOT*k + 1 || en_we[k] !== 1'b0 || en_addr[k] !== ia)
                        $display("FAIL rand%0d_if_cmd: got cyc=%0d we=%b addr=%h want cyc=%0d we=0 addr=%h",
                                 it, en_cyc[k], en_we[k], en_addr[k], SLOT*k + 1, ia);
                    else n_pass++;
                end
            end
            if (want_if) begin
                exp_if_rdata = rom(ia);
                n_checks++;
                if (ifr_cyc.size() != 1 || ifr_cyc[0] != t_if || ifr_dat[0] !== exp_if_rdata)
                    $display("FAIL rand%0d_if_ready: got n=%0d cyc=%0d data=%h want 1 %0d %h",
                             it, ifr_cyc.size(), ifr_cyc[0], ifr_dat[0], t_if, exp_if_rdata);
                else n_pass++;
            end
            if (dm) begin
                if (!dw) exp_dm_rdata = rom(da);
                n_checks++;
                if (dmr_cyc.size() != 1 || dmr_cyc[0] != t_dm || dmr_dat[0] !== exp_dm_rdata)
                    $display("FAIL rand%0d_dm_ready: got n=%0d cyc=%0d data=%h want 1 %0d %h",
                             it, dmr_cyc.size(), dmr_cyc[0], dmr_dat[0], t_dm, exp_dm_rdata);
                else n_pass++;
            end
            n_checks++;
            if (st_if[13:0] !== x_if || st_mem[13:0] !== x_mem)
                $display("FAIL rand%0d_stall: got if=%b mem=%b want if=%b mem=%b", it, st_if[13:0], st_mem[13:0], x_if, x_mem);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_fairness();
        test_store();
        test_reset_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
